kes_result_dispatcher: RTL
==========================

# kes_result_dispatcher

Downstream stage of the inter-channel syndrome buffer. Captures the channel/chunk tag when a syndrome set is launched into the single shared key-equation solver (KES), waits for the KES result or a watchdog timeout, and delivers the error-locator polynomial (ELP) to the owning channel's Chien-search stage over a per-channel valid/ready handshake. It also generates the `KES available` signal that gates the upstream channel arbiter.

## Interface
- `Channel`, default 4: number of channels; the channel select is one-hot over this width.
- `GaloisFieldDegree`, default 12: width of one GF element.
- `MaxErrorCount`, default 14: ELP carries `MaxErrorCount+1` coefficients.
- `KESTimeout`, default 255: maximum number of RUN cycles before abort; 8-bit counter.

Ports:
- `iClock`  in  1  clock.
- `iReset`  in  1  synchronous, active-high reset.
- `iExecuteKES`  in  1  one-cycle launch pulse from the syndrome buffer.
- `iChannelSel`  in  Channel  one-hot owner of the launched syndromes.
- `iErroredChunkNumber`  in  1  chunk index within the page.
- `iDataFowarding`  in  1  forwarding flag, carried with the tag.
- `iLastChunk`  in  1  last chunk of the sequence, carried with the tag.
- `oKESAvailable`  out  1  registered; block accepts a launch.
- `iKESDone`  in  1  one-cycle KES completion pulse.
- `iKESFail`  in  1  uncorrectable flag; valid with `iKESDone`.
- `iELPDegree`  in  4  ELP degree; valid with `iKESDone`.
- `iELPCoefficients`  in  GaloisFieldDegree*(MaxErrorCount+1)  ELP; valid with `iKESDone`.
- `oCSValid`  out  Channel  result valid for channel c; at most one bit high.
- `iCSReady`  in  Channel  channel c accepts the result.
- `oELPCoefficients`, `oELPDegree`, `oDecodeFail`, `oChunkNumber`, `oDataFowarding`, `oLastChunk`  out  matching widths  shared result bus; valid while any `oCSValid` bit is high.
- `oProtocolError`  out  1  sticky; cleared only by reset.
- `oTimeoutCount`  out  8  saturating count of watchdog aborts.

## Operation
- FSM states: IDLE, RUN, DELIVER. Reset forces IDLE.
- Reset values: every output is 0. This includes `oKESAvailable`, which rises the first cycle after reset deasserts.
- IDLE:
  - `oKESAvailable`=1.
  - `iExecuteKES` with exactly one bit set in `iChannelSel`: latch tag (channel, chunk, forwarding, last), clear the watchdog, go to RUN.
  - `iExecuteKES` with zero or multiple bits set in `iChannelSel`: drop the launch, set `oProtocolError`, stay in IDLE.
- RUN:
  - `oKESAvailable`=0.
  - The watchdog increments every cycle.
  - `iKESDone`: latch fail, degree and coefficients into the result register, go to DELIVER.
  - Watchdog reaching `KESTimeout` without `iKESDone`: load fail=1, degree=0, coefficients=0; increment `oTimeoutCount` (saturates at 255); go to DELIVER.
  - `iKESDone` on the timeout cycle: done wins; no timeout is counted.
- DELIVER:
  - `oCSValid` = tag one-hot; the bus holds steady until handshake.
  - `oCSValid[c]&iCSReady[c]` completes the transfer. Next cycle: return to IDLE, `oCSValid`=0, `oKESAvailable`=1.
  - Ready on channels other than the owner is ignored.
- Illegal events:
  - `iExecuteKES` outside IDLE is ignored and sets `oProtocolError`.
  - `iKESDone` outside RUN is ignored and sets `oProtocolError`.
- Reset mid-RUN or mid-DELIVER: the tag and result are discarded and no handshake completes.
- The result bus is 0 whenever `oCSValid` is 0.

## Timing
- `iExecuteKES` at cycle t: RUN at t+1; `oKESAvailable` low at t+1.
- `iKESDone` at cycle t: `oCSValid` high at t+1.
- Timeout: `iExecuteKES` at t0 gives `oCSValid` at t0+1+`KESTimeout`+1 (257 with the default).
- Handshake at cycle t: `oKESAvailable`=1 at t+1; a new launch is accepted at t+1.
- Minimum launch-to-launch interval, with zero-latency KES and always-ready CS: 3 cycles.
- Single outstanding KES job at any time; no overlap of RUN and DELIVER.

## Structure
- Shared package holds:
  - FSM state encoding (2 bits).
  - Tag field offsets/width (Channel+3).
  - ELP width constant `GaloisFieldDegree*(MaxErrorCount+1)`.
  - Timeout counter width (8).
- One natural sub-module: `kes_run_watchdog`, an 8-bit clear/enable counter with a terminal-count flag at `KESTimeout`. Everything else stays in the top module.

## Test plan
- Normal path: launch `iChannelSel`=4'b0100, chunk=1, last=1; `iKESDone` 10 cycles later with degree=3, fail=0 and known coefficients; CS ready held high. Required: `oCSValid`=4'b0100 exactly 1 cycle after done; bus matches; `oKESAvailable`=1 the next cycle.
- Backpressure: same launch, but `iCSReady[2]` withheld for 20 cycles while `iCSReady[0]`=1. Required: valid and bus stable for 20 cycles; no transfer; a second launch during the stall sets `oProtocolError` and is dropped.
- Timeout: launch on channel 1, no done. Required: `oCSValid`=4'b0010 at t0+257 with fail=1, degree=0, coefficients=0; `oTimeoutCount`=1. Repeat the scenario 300 times; required: count saturates at 255.
- Done on the timeout cycle: `iKESDone` exactly at watchdog terminal count. Required: the real result is delivered and `oTimeoutCount` is unchanged.
- Illegal launches: `iChannelSel`=0 and `iChannelSel`=4'b0011 in IDLE, and a stray `iKESDone` in IDLE. Required: state stays IDLE, `oProtocolError`=1, no `oCSValid`.
- Reset mid-operation: `iReset` for 1 cycle in RUN, and again in DELIVER. Required: all outputs 0 during reset; `oKESAvailable`=1 the cycle after; a subsequent `iKESDone` flags a protocol error and no stale result is delivered.

Source files
------------

// File: rtl/kes_result_dispatcher_pkg.sv
// Shared definitions for the KES result dispatcher: FSM encoding, tag layout,
// ELP bus width helper and the watchdog counter width.
// Latency: n/a (package). Backpressure: n/a.
package kes_result_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DELIVER = 2'd2
    } kes_state_t;

    // Tag layout, LSB first: last, forwarding, chunk, then the one-hot channel.
    localparam int TAG_LAST_BIT  = 0;
    localparam int TAG_FWD_BIT   = 1;
    localparam int TAG_CHUNK_BIT = 2;
    localparam int TAG_CH_LSB    = 3;

    localparam int TIMEOUT_CNT_W = 8;

    function automatic int tag_width(input int channel);
        return channel + 3;
    endfunction

    function automatic int elp_width(input int gf_degree, input int max_errors);
        return gf_degree * (max_errors + 1);
    endfunction

endpackage

// File: rtl/kes_run_watchdog.sv
// Watchdog for one KES job: clear/enable counter with a terminal flag at KESTimeout.
// Latency: terminal is combinational from the registered count.
// Backpressure: none; counts whenever enabled.
// Ports: iClock/iReset, clear (restart at 0), enable (count this cycle), terminal.
module kes_run_watchdog
    import kes_result_dispatcher_pkg::*;
#(
    parameter int KESTimeout = 255
) (
    input  logic iClock,
    input  logic iReset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [TIMEOUT_CNT_W-1:0] count;

    always_ff @(posedge iClock) begin
        if (iReset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TIMEOUT_CNT_W'(KESTimeout));

endmodule

// File: rtl/kes_result_dispatcher.sv
// Tags a launched KES job, waits for its result or a watchdog abort, and hands the
// ELP to the owning channel. Latency: done -> oCSValid 1 cycle; launch -> abort
// result KESTimeout+2 cycles. Backpressure: result held until the owner's iCSReady.
// Ports: launch (iExecuteKES, iChannelSel, tag bits), oKESAvailable, KES result
// (iKESDone, iKESFail, iELPDegree, iELPCoefficients), per-channel oCSValid/iCSReady,
// shared result bus, sticky oProtocolError, saturating oTimeoutCount.
module kes_result_dispatcher
    import kes_result_dispatcher_pkg::*;
#(
    parameter int Channel           = 4,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCount     = 14,
    parameter int KESTimeout        = 255,
    localparam int ElpW             = elp_width(GaloisFieldDegree, MaxErrorCount)
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iExecuteKES,
    input  logic [Channel-1:0]       iChannelSel,
    input  logic                     iErroredChunkNumber,
    input  logic                     iDataFowarding,
    input  logic                     iLastChunk,
    output logic                     oKESAvailable,
    input  logic                     iKESDone,
    input  logic                     iKESFail,
    input  logic [3:0]               iELPDegree,
    input  logic [ElpW-1:0]          iELPCoefficients,
    output logic [Channel-1:0]       oCSValid,
    input  logic [Channel-1:0]       iCSReady,
    output logic [ElpW-1:0]          oELPCoefficients,
    output logic [3:0]               oELPDegree,
    output logic                     oDecodeFail,
    output logic                     oChunkNumber,
    output logic                     oDataFowarding,
    output logic                     oLastChunk,
    output logic                     oProtocolError,
    output logic [TIMEOUT_CNT_W-1:0] oTimeoutCount
);

    localparam int TagW = tag_width(Channel);

    kes_state_t      state;
    logic [TagW-1:0] tag;
    logic            launch_ok;
    logic            bad_launch;
    logic            bad_done;
    logic            handshake;
    logic            wd_terminal;

    always_comb begin
        launch_ok  = (state == ST_IDLE) && iExecuteKES && $onehot(iChannelSel);
        // Covers both a malformed select in IDLE and any launch while busy.
        bad_launch = iExecuteKES && !launch_ok;
        bad_done   = iKESDone && (state != ST_RUN);
        // Only the owner's ready matters; oCSValid carries a single bit.
        handshake  = (state == ST_DELIVER) && |(oCSValid & iCSReady);
    end

    kes_run_watchdog #(
        .KESTimeout (KESTimeout)
    ) u_watchdog (
        .iClock   (iClock),
        .iReset   (iReset),
        .clear    (launch_ok),
        .enable   (state == ST_RUN),
        .terminal (wd_terminal)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state            <= ST_IDLE;
            tag              <= '0;
            oKESAvailable    <= 1'b0;
            oCSValid         <= '0;
            oELPCoefficients <= '0;
            oELPDegree       <= '0;
            oDecodeFail      <= 1'b0;
            oChunkNumber     <= 1'b0;
            oDataFowarding   <= 1'b0;
            oLastChunk       <= 1'b0;
            oProtocolError   <= 1'b0;
            oTimeoutCount    <= '0;
        end else begin
            if (bad_launch || bad_done) begin
                oProtocolError <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    oKESAvailable <= 1'b1;
                    if (launch_ok) begin
                        tag           <= {iChannelSel, iErroredChunkNumber, iDataFowarding, iLastChunk};
                        oKESAvailable <= 1'b0;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A done arriving on the terminal cycle takes precedence over the abort.
                    if (iKESDone || wd_terminal) begin
                        state          <= ST_DELIVER;
                        oCSValid       <= tag[TAG_CH_LSB +: Channel];
                        oChunkNumber   <= tag[TAG_CHUNK_BIT];
                        oDataFowarding <= tag[TAG_FWD_BIT];
                        oLastChunk     <= tag[TAG_LAST_BIT];
                        if (iKESDone) begin
                            oDecodeFail      <= iKESFail;
                            oELPDegree       <= iELPDegree;
                            oELPCoefficients <= iELPCoefficients;
                        end else begin
                            oDecodeFail      <= 1'b1;
                            oELPDegree       <= '0;
                            oELPCoefficients <= '0;
                            if (oTimeoutCount != '1) begin
                                oTimeoutCount <= oTimeoutCount + 1'b1;
                            end
                        end
                    end
                end
                ST_DELIVER: begin
                    // Clearing the bus on handshake keeps it zero whenever nothing is valid.
                    if (handshake) begin
                        state            <= ST_IDLE;
                        oKESAvailable    <= 1'b1;
                        oCSValid         <= '0;
                        oELPCoefficients <= '0;
                        oELPDegree       <= '0;
                        oDecodeFail      <= 1'b0;
                        oChunkNumber     <= 1'b0;
                        oDataFowarding   <= 1'b0;
                        oLastChunk       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
